// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial 4-bit subtractor computing A - B - Bin, one bit per clock,
//   LSB first. A start sampled in IDLE or DONE captures the operands; four
//   RUN cycles later the FSM enters DONE, publishing Diff/Bout and pulsing
//   done for one cycle. Results hold until the next completion.
//
// Optional feature: define SUB_OVF_EN to add the signed-overflow output Ovf.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   begin a subtraction (ignored while busy)
//   A      in   [3:0] minuend
//   B      in   [3:0] subtrahend
//   Bin    in   borrow-in
//   Diff   out  [3:0] A - B - Bin (mod 16)
//   Bout   out  borrow-out (A < B + Bin, unsigned)
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when Diff/Bout become valid
//   Ovf    out  signed overflow (SUB_OVF_EN only)
module serial_subtractor (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Bin,
  output logic [3:0] Diff,
  output logic       Bout,
  output logic       busy,
  output logic       done
`ifdef SUB_OVF_EN
  ,
  output logic       Ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_res;
  logic [1:0] r_cnt;
  logic       r_brw;

  logic       w_accept;
  logic       w_last;
  logic       w_d;
  logic       w_brw_next;

  // Operands are only loaded outside RUN, so a start during RUN is ignored.
  assign w_accept   = start && (r_state != S_RUN);
  assign w_last     = (r_state == S_RUN) && (r_cnt == 2'd3);
  assign w_d        = r_a[0] ^ r_b[0] ^ r_brw;
  assign w_brw_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == 2'd3) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef SUB_OVF_EN
  // Sign bits are kept separately because the operand registers shift away.
  logic r_a3;
  logic r_b3;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_brw <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
`ifdef SUB_OVF_EN
      r_a3  <= 1'b0;
      r_b3  <= 1'b0;
      Ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_res <= '0;
      r_cnt <= '0;
      r_brw <= Bin;
`ifdef SUB_OVF_EN
      r_a3  <= A[3];
      r_b3  <= B[3];
`endif
    end else if (r_state == S_RUN) begin
      r_a   <= {1'b0, r_a[3:1]};
      r_b   <= {1'b0, r_b[3:1]};
      r_res <= {w_d, r_res[3:1]};
      r_cnt <= r_cnt + 2'd1;
      r_brw <= w_brw_next;
      // Outputs are written only on the final bit so partial sums never show.
      if (w_last) begin
        Diff <= {w_d, r_res[3:1]};
        Bout <= w_brw_next;
`ifdef SUB_OVF_EN
        Ovf  <= (r_a3 != r_b3) && (w_d != r_a3);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Bin;
  logic [3:0] Diff;
  logic       Bout;
  logic       busy;
  logic       done;
`ifdef SUB_OVF_EN
  logic       Ovf;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [3:0] prev_diff;
  logic       prev_bout;

  serial_subtractor dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Diff  (Diff),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
`ifdef SUB_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ovf(input string name, input logic exp);
`ifdef SUB_OVF_EN
    chk(name, {31'd0, Ovf}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unused %s", name);
`endif
  endtask

  // Drive at negedge, sample at negedge; start is seen by the following posedge.
  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    A = v.a; B = v.b; Bin = v.bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d busy_k0", idx), {31'd0, busy}, 32'd1);
    chk($sformatf("v%0d done_k0", idx), {31'd0, done}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d done_k%0d", idx, k), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d diff_hold_k%0d", idx, k), {28'd0, Diff}, {28'd0, prev_diff});
      chk($sformatf("v%0d bout_hold_k%0d", idx, k), {31'd0, Bout}, {31'd0, prev_bout});
    end
    @(negedge clk);
    chk($sformatf("v%0d done", idx), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d busy_done", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d diff", idx), {28'd0, Diff}, {28'd0, v.diff});
    chk($sformatf("v%0d bout", idx), {31'd0, Bout}, {31'd0, v.bout});
    chk_ovf($sformatf("v%0d ovf", idx), v.ovf);
    @(negedge clk);
    chk($sformatf("v%0d done_cleared", idx), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d busy_idle", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d diff_held", idx), {28'd0, Diff}, {28'd0, v.diff});
    prev_diff = v.diff;
    prev_bout = v.bout;
  endtask

  initial begin
    //          a        b        bin   diff     bout  ovf
    vecs[0] = '{4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0};
    vecs[1] = '{4'b0101, 4'b0011, 1'b1, 4'b0001, 1'b0, 1'b0};
    vecs[2] = '{4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0};
    vecs[3] = '{4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b1};
    vecs[4] = '{4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0, 1'b0};
    vecs[5] = '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1};
    vecs[6] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[7] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[8] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};
    vecs[9] = '{4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    prev_diff = '0; prev_bout = 1'b0;
    #1;
    chk("reset diff", {28'd0, Diff}, 32'd0);
    chk("reset bout", {31'd0, Bout}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk_ovf("reset ovf", 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Sub-cycle start glitch between edges must be ignored.
    #1 start = 1'b1;
    #2 start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("glitch busy_%0d", k), {31'd0, busy}, 32'd0);
      chk($sformatf("glitch done_%0d", k), {31'd0, done}, 32'd0);
    end

    for (int i = 0; i < 10; i++) run_vec(i);

    // Operands and start changed mid-RUN: result and single done unaffected.
    @(negedge clk);
    A = 4'b1010; B = 4'b0101; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 4'b0000; B = 4'b0000; Bin = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midrun done_k2", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("midrun done_k3", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("midrun done", {31'd0, done}, 32'd1);
    chk("midrun diff", {28'd0, Diff}, 32'h5);
    chk("midrun bout", {31'd0, Bout}, 32'd0);
    chk_ovf("midrun ovf", 1'b1);
    @(negedge clk);
    chk("midrun single pulse", {31'd0, done}, 32'd0);
    chk("midrun no restart", {31'd0, busy}, 32'd0);

    // Reset mid-RUN: outputs clear at once, no done afterwards.
    @(negedge clk);
    A = 4'b1111; B = 4'b0001; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort diff", {28'd0, Diff}, 32'd0);
    chk("abort bout", {31'd0, Bout}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk_ovf("abort ovf", 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b0;
      chk($sformatf("abort no_done_%0d", k), {31'd0, done}, 32'd0);
    end
    prev_diff = '0; prev_bout = 1'b0;
    run_vec(4);

    // start held high: done every 5 clocks, busy low only in DONE.
    @(negedge clk);
    A = 4'b0011; B = 4'b0001; Bin = 1'b0; start = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk($sformatf("b2b done_%0d", k), {31'd0, done}, (k % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("b2b busy_%0d", k), {31'd0, busy}, (k % 5 == 4) ? 32'd0 : 32'd1);
      if (k % 5 == 4) chk($sformatf("b2b diff_%0d", k), {28'd0, Diff}, 32'h2);
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
